// File: rtl/spm_pkg.sv
// rtl/spm_pkg.sv - shared state encodings, width defaults and opcodes for the RISC SPM memory side
package spm_pkg;

    localparam int SPM_ADDR_W = 8;
    localparam int SPM_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUMP = 2'd2
    } spm_state_t;

    // Instruction opcodes occupy the upper nibble of an instruction byte
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_RD  = 4'd5;
    localparam logic [3:0] OP_WR  = 4'd6;
    localparam logic [3:0] OP_BR  = 4'd7;
    localparam logic [3:0] OP_BRZ = 4'd8;

    // Assemble an instruction byte from opcode and source/destination register fields
    function automatic logic [7:0] spm_instr(input logic [3:0] op,
                                             input logic [1:0] src,
                                             input logic [1:0] dst);
        return {op, src, dst};
    endfunction

endpackage

// File: rtl/spm_mem_array.sv
// rtl/spm_mem_array.sv - word memory with one synchronous write port and two asynchronous read ports
module spm_mem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_cpu,
    output logic [DATA_W-1:0] rdata_cpu,
    input  logic [ADDR_W-1:0] raddr_dump,
    output logic [DATA_W-1:0] rdata_dump
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Contents survive reset so a partially reloaded program keeps untouched words
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_cpu  = mem[raddr_cpu];
    assign rdata_dump = mem[raddr_dump];

endmodule

// File: rtl/spm_memory_responder.sv
// rtl/spm_memory_responder.sv - memory responder with program loader and dump port for the RISC SPM
module spm_memory_responder
    import spm_pkg::*;
#(
    parameter int ADDR_W = SPM_ADDR_W,
    parameter int DATA_W = SPM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              write,
    output logic [DATA_W-1:0] mem_word,
    output logic              cpu_hold,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              load_done,
    input  logic              dump_req,
    output logic              dump_valid,
    output logic [DATA_W-1:0] dump_data,
    input  logic              dump_ready,
    output logic              wr_err
);

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    spm_state_t        state;
    logic [ADDR_W-1:0] ld_ptr;
    logic [ADDR_W-1:0] dump_ptr;

    logic              ld_fire;
    logic              cpu_wr;
    logic              dump_fire;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // The loader owns the write port in LOAD, the CPU only in RUN; DUMP never writes
    assign ld_fire   = (state == ST_LOAD) && ld_valid && ld_ready;
    assign cpu_wr    = (state == ST_RUN) && write;
    assign dump_fire = dump_valid && dump_ready;
    assign mem_we    = ld_fire || cpu_wr;
    assign mem_waddr = ld_fire ? ld_ptr  : address;
    assign mem_wdata = ld_fire ? ld_data : data_in;

    spm_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk        (clk),
        .we         (mem_we),
        .waddr      (mem_waddr),
        .wdata      (mem_wdata),
        .raddr_cpu  (address),
        .rdata_cpu  (mem_word),
        .raddr_dump (dump_ptr),
        .rdata_dump (dump_data)
    );

    // Mode sequencer; handshake and hold outputs are registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_LOAD;
            ld_ptr     <= '0;
            dump_ptr   <= '0;
            cpu_hold   <= 1'b1;
            ld_ready   <= 1'b1;
            load_done  <= 1'b0;
            dump_valid <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (ld_fire) begin
                        ld_ptr <= ld_ptr + 1'b1;
                        if (ld_last || ld_ptr == PTR_MAX) begin
                            state     <= ST_RUN;
                            ld_ptr    <= '0;
                            cpu_hold  <= 1'b0;
                            ld_ready  <= 1'b0;
                            load_done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (dump_req) begin
                        state      <= ST_DUMP;
                        dump_ptr   <= '0;
                        cpu_hold   <= 1'b1;
                        load_done  <= 1'b0;
                        dump_valid <= 1'b1;
                    end
                end
                ST_DUMP: begin
                    if (dump_fire) begin
                        dump_ptr <= dump_ptr + 1'b1;
                        if (dump_ptr == PTR_MAX) begin
                            state      <= ST_LOAD;
                            ld_ptr     <= '0;
                            ld_ready   <= 1'b1;
                            dump_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= ST_LOAD;
                    ld_ptr     <= '0;
                    cpu_hold   <= 1'b1;
                    ld_ready   <= 1'b1;
                    load_done  <= 1'b0;
                    dump_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flag for CPU writes attempted while the processor should be held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err <= 1'b0;
        end else if (write && state != ST_RUN) begin
            wr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spm_memory_responder.sv
// tb/tb_spm_memory_responder.sv - directed self-checking bench for spm_memory_responder
module tb_spm_memory_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] address = '0;
    logic [7:0] data_in = '0;
    logic       write = 1'b0;
    logic [7:0] mem_word;
    logic       cpu_hold;
    logic       ld_valid = 1'b0;
    logic [7:0] ld_data = '0;
    logic       ld_last = 1'b0;
    logic       ld_ready;
    logic       load_done;
    logic       dump_req = 1'b0;
    logic       dump_valid;
    logic [7:0] dump_data;
    logic       dump_ready = 1'b0;
    logic       wr_err;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] model [256];
    logic       known [256];

    spm_memory_responder #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .data_in    (data_in),
        .write      (write),
        .mem_word   (mem_word),
        .cpu_hold   (cpu_hold),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .load_done  (load_done),
        .dump_req   (dump_req),
        .dump_valid (dump_valid),
        .dump_data  (dump_data),
        .dump_ready (dump_ready),
        .wr_err     (wr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_data  = b;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic read_check(input string tag, input int a);
        address = 8'(a);
        #1;
        check(tag, mem_word, model[a]);
    endtask

    // Drain all 256 words, stalling once at word 5 and once at word 200
    task automatic dump_all();
        int  idx = 0;
        bit  s5  = 0;
        bit  s200 = 0;
        for (int cyc = 0; cyc < 600 && idx < 256; cyc++) begin
            if ((idx == 5 && !s5) || (idx == 200 && !s200)) begin
                dump_ready = 1'b0;
                if (idx == 5) s5 = 1; else s200 = 1;
                if (known[idx]) check("dump_stall_data", dump_data, model[idx]);
            end else begin
                dump_ready = 1'b1;
            end
            if (dump_valid && dump_ready) begin
                if (known[idx]) check($sformatf("dump_word_%0d", idx), dump_data, model[idx]);
                idx++;
            end
            step();
        end
        dump_ready = 1'b0;
        check("dump_count", idx, 256);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            known[i] = 1'b0;
            model[i] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_ld_ready", ld_ready, 1);
        check("rst_load_done", load_done, 0);
        check("rst_dump_valid", dump_valid, 0);
        check("rst_wr_err", wr_err, 0);
        rst = 1'b0;
        step();

        // Four-byte program ending with ld_last
        load_byte(8'h01, 1'b0);
        load_byte(8'h12, 1'b0);
        load_byte(8'h73, 1'b0);
        check("load4_hold_before_last", cpu_hold, 1);
        load_byte(8'h00, 1'b1);
        check("load4_cpu_hold", cpu_hold, 0);
        check("load4_load_done", load_done, 1);
        check("load4_ld_ready", ld_ready, 0);
        model[0] = 8'h01; model[1] = 8'h12; model[2] = 8'h73; model[3] = 8'h00;
        for (int i = 0; i < 4; i++) known[i] = 1'b1;
        for (int i = 0; i < 4; i++) read_check($sformatf("load4_mem_%0d", i), i);

        // CPU write: old value visible in the write cycle, new value afterwards
        address = 8'h20; data_in = 8'h5A; write = 1'b1;
        step();
        data_in = 8'hA5;
        #1;
        check("run_wr_old", mem_word, 8'h5A);
        step();
        write = 1'b0;
        check("run_wr_new", mem_word, 8'hA5);
        model[8'h20] = 8'hA5; known[8'h20] = 1'b1;
        check("run_wr_err_clear", wr_err, 0);

        // Enter DUMP, try a write there, then drain
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
        check("dump_valid_up", dump_valid, 1);
        check("dump_cpu_hold", cpu_hold, 1);
        check("dump_load_done", load_done, 0);
        address = 8'h01; data_in = 8'hEE; write = 1'b1;
        step();
        write = 1'b0;
        check("dump_wr_err", wr_err, 1);
        check("dump_ptr_hold", dump_data, 8'h01);
        dump_all();
        check("post_dump_ld_ready", ld_ready, 1);
        check("post_dump_cpu_hold", cpu_hold, 1);
        check("post_dump_dump_valid", dump_valid, 0);
        check("post_dump_wr_err", wr_err, 1);

        // Reset clears wr_err; a write in LOAD sets it and leaves the array alone
        rst = 1'b1;
        #1;
        check("rst2_wr_err", wr_err, 0);
        step();
        rst = 1'b0;
        address = 8'h01; data_in = 8'hEE; write = 1'b1;
        step();
        write = 1'b0;
        check("load_wr_err", wr_err, 1);
        read_check("load_wr_ignored", 1);

        // Full 256-byte load with ld_valid toggling and no ld_last
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i * 7 + 3);
            if (i == 255) check("load256_hold_before_last", cpu_hold, 1);
            load_byte(b, 1'b0);
            model[i] = b;
            known[i] = 1'b1;
            if (i < 255) step();
        end
        check("load256_cpu_hold", cpu_hold, 0);
        check("load256_load_done", load_done, 1);
        for (int i = 0; i < 256; i++) read_check($sformatf("load256_mem_%0d", i), i);

        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
        dump_all();
        check("dump2_ld_ready", ld_ready, 1);
        check("dump2_wr_err_sticky", wr_err, 1);

        // Reset after 10 of 20 bytes restarts at address 0, keeping contents
        for (int i = 0; i < 10; i++) begin
            load_byte(8'h40 + 8'(i), 1'b0);
            model[i] = 8'h40 + 8'(i);
        end
        rst = 1'b1;
        #1;
        check("midload_rst_cpu_hold", cpu_hold, 1);
        check("midload_rst_ld_ready", ld_ready, 1);
        check("midload_rst_wr_err", wr_err, 0);
        step();
        rst = 1'b0;
        load_byte(8'hFF, 1'b1);
        model[0] = 8'hFF;
        check("reload_load_done", load_done, 1);
        for (int i = 0; i < 11; i++) read_check($sformatf("reload_mem_%0d", i), i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spm_memory_responder.md
Name: spm_memory_responder

Overview:
- Memory-side responder for the RISC SPM processor.
- Serves the control unit's fetch, read and write cycles: address from Add_R, write strobe, store data from Bus_1, read word to the Bus_2 mux.
- Adds a byte-stream program loader that holds the CPU in reset while filling memory, and a dump port that streams memory out after a run, for test benches.

Parameters:
- ADDR_W, 8, address width; memory depth is 2**ADDR_W.
- DATA_W, 8, word width; matches the instruction width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- address  in  ADDR_W  from Add_R register
- data_in  in  DATA_W  store data from Bus_1
- write  in  1  CPU write strobe from the control unit
- mem_word  out  DATA_W  read data to the Bus_2 mux
- cpu_hold  out  1  high holds the processor in reset/idle
- ld_valid  in  1  loader byte valid
- ld_data  in  DATA_W  loader byte
- ld_last  in  1  marks the final loader byte
- ld_ready  out  1  loader may transfer
- load_done  out  1  program loaded, CPU running
- dump_req  in  1  request memory dump (level, sampled in RUN)
- dump_valid  out  1  dump word valid
- dump_data  out  DATA_W  dump word
- dump_ready  in  1  dump consumer accepts
- wr_err  out  1  sticky: CPU write seen while not in RUN

Behaviour:
- State machine: LOAD, RUN, DUMP. Registers ld_ptr and dump_ptr are ADDR_W wide.
- Reset (asynchronous, rst=1) values: state=LOAD, ld_ptr=0, dump_ptr=0, cpu_hold=1, ld_ready=1, load_done=0, dump_valid=0, wr_err=0.
- Memory array contents are not reset. A reset in mid-load or mid-dump restarts loading at address 0 and keeps existing contents.
- mem_word = mem[address] combinationally, with zero latency. Fetch (fet2), read (rd1/rd2) and branch (br1/br2) cycles use it in the same cycle Add_R is valid.
- dump_data = mem[dump_ptr] combinationally.
- LOAD state:
  - cpu_hold=1, ld_ready=1, dump_valid=0.
  - On ld_valid&ld_ready: mem[ld_ptr]<=ld_data, ld_ptr<=ld_ptr+1.
  - If ld_last=1 or ld_ptr==2**ADDR_W-1 on that transfer: go to RUN next cycle and reset ld_ptr to 0.
  - Any write=1 in this state is ignored (no array update) and sets wr_err.
- RUN state:
  - cpu_hold=0, ld_ready=0, load_done=1.
  - write=1 writes mem[address]<=data_in at the rising edge.
  - Same-cycle read of the written address returns the old value; the new value is visible the next cycle.
  - dump_req=1 moves to DUMP next cycle with dump_ptr=0. A write in that same cycle still commits.
  - Dump is intended only after the program reaches halt. An instruction in flight is abandoned because cpu_hold rises.
- DUMP state:
  - cpu_hold=1, load_done=0, dump_valid=1.
  - On dump_valid&dump_ready: dump_ptr<=dump_ptr+1.
  - Acceptance at dump_ptr==2**ADDR_W-1 moves to LOAD (ld_ptr=0, ld_ready=1) for the next program. dump_ptr wraps to 0.
  - write=1 is ignored and sets wr_err.
  - dump_req is ignored outside RUN.
- cpu_hold, ld_ready, load_done and dump_valid are decoded from the state register (registered, glitch-free).
- wr_err clears only on rst.

Decomposition:
- Shared package spm_pkg holds:
  - state encodings LOAD/RUN/DUMP
  - ADDR_W/DATA_W defaults
  - opcode constants (NOP..BRZ, shared with the control unit and the bench assembler)
- One natural sub-module: spm_mem_array. It has one synchronous write port and two asynchronous read ports (CPU address, dump pointer). The write-port mux between loader and CPU sits in the parent.

Test Plan:
- Reset, then stream bytes 0x01,0x12,0x73,0x00 with ld_last on the 4th -> mem[0..3] hold those bytes; cpu_hold falls and load_done rises one cycle after the 4th transfer; ld_ptr=0.
- In RUN, address=0x20, data_in=0xA5, write=1 for one cycle -> mem_word shows the old value that cycle and 0xA5 the next.
- Load with ld_valid toggling 1/0 and no ld_last for 256 bytes -> auto-transition to RUN after byte 255; all 256 locations match the stream.
- In RUN, assert dump_req; dump_ready=1 except stalls at words 5 and 200 -> 256 words in address order, no duplicates or skips; returns to LOAD with ld_ready=1.
- Pulse write=1 during LOAD and during DUMP -> array unchanged, wr_err=1 and stays high until rst.
- Assert rst after 10 of 20 loader bytes -> cpu_hold=1, ld_ptr=0; reloading 0xFF at address 0 overwrites; bytes 1..9 keep the earlier values.
